// File: rtl/wsg_voice_sequencer_if.sv
// Signal bundle for the WSG voice sequencer: CPU register writes, the shared
// waveform ROM port and the mixed sample output.
interface wsg_voice_sequencer_if;
    logic        wr_en;
    logic [15:0] ram_addr;
    logic [7:0]  cpu_data;
    logic        snd_enable;
    logic [7:0]  rom_addr;
    logic [3:0]  rom_data;
    logic [9:0]  sample_out;
    logic        sample_valid;

    // The master side plays both the CPU and the waveform ROM.
    modport master (
        output wr_en, ram_addr, cpu_data, snd_enable, rom_data,
        input  rom_addr, sample_out, sample_valid
    );

    modport slave (
        input  wr_en, ram_addr, cpu_data, snd_enable, rom_data,
        output rom_addr, sample_out, sample_valid
    );
endinterface

// File: rtl/wsg_voice_sequencer.sv
// Three-voice wavetable sequencer: owns per-voice registers and accumulators and,
// once per sample tick, walks voices 0..2 through one shared ROM and one MAC.
module wsg_voice_sequencer #(
    parameter int unsigned TICK_DIV = 1042,
    parameter logic [15:0] REG_BASE = 16'h5040
) (
    input  logic                 clk,
    input  logic                 rst,
    wsg_voice_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ACC0, S_WAIT0, S_MAC0, S_ACC1, S_WAIT1, S_MAC1,
        S_ACC2, S_WAIT2, S_MAC2, S_OUT
    } state_t;

    state_t      state, state_next;
    logic [15:0] tick_cnt;
    logic        tick;

    logic [2:0]  wave [3];
    logic [19:0] freq [3];
    logic [3:0]  vol  [3];
    logic [19:0] acc  [3];
    logic [9:0]  mix;
    logic [7:0]  rom_addr_q;
    logic [9:0]  sample_q;
    logic        valid_q;

    logic        start, acc_step, mac_step, out_step;
    logic [1:0]  voice;
    logic [19:0] acc_sum;
    logic [7:0]  product;

    logic [15:0] reg_off;
    logic        in_window;
    logic [4:0]  off;
    logic [3:0]  nib;
    logic [2:0]  v1_idx, v2_idx;
    logic        unused_data;

    assign tick = (tick_cnt == 16'(TICK_DIV - 1));

    // NOTE: sequential state uses <= so every flop samples pre-edge values; this is
    // also why a register read on the edge of its own write still sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        acc_step   = 1'b0;
        mac_step   = 1'b0;
        out_step   = 1'b0;
        voice      = 2'd0;
        case (state)
            S_IDLE:  if (tick) begin state_next = S_ACC0; start = 1'b1; end
            S_ACC0:  begin acc_step = 1'b1; state_next = S_WAIT0; end
            S_WAIT0: state_next = S_MAC0;
            S_MAC0:  begin mac_step = 1'b1; state_next = S_ACC1; end
            S_ACC1:  begin acc_step = 1'b1; voice = 2'd1; state_next = S_WAIT1; end
            S_WAIT1: state_next = S_MAC1;
            S_MAC1:  begin mac_step = 1'b1; voice = 2'd1; state_next = S_ACC2; end
            S_ACC2:  begin acc_step = 1'b1; voice = 2'd2; state_next = S_WAIT2; end
            S_WAIT2: state_next = S_MAC2;
            S_MAC2:  begin mac_step = 1'b1; voice = 2'd2; state_next = S_OUT; end
            S_OUT:   begin out_step = 1'b1; state_next = S_IDLE; end
            default: state_next = S_IDLE;
        endcase
    end

    assign acc_sum = acc[voice] + freq[voice];
    assign product = 8'(bus.rom_data) * 8'(vol[voice]);

    // Offsets outside 0..31 land in reg_off[15:5], including addresses below the base.
    assign reg_off     = bus.ram_addr - REG_BASE;
    assign in_window   = (reg_off[15:5] == 11'd0);
    assign off         = reg_off[4:0];
    assign nib         = bus.cpu_data[3:0];
    assign v1_idx      = 3'(off - 5'h15);
    assign v2_idx      = 3'(off - 5'h1A);
    assign unused_data = ^bus.cpu_data[7:4];

    // NOTE: the register file is only a few flops, so every entry is cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < 3; v++) begin
                wave[v] <= '0;
                freq[v] <= '0;
                vol[v]  <= '0;
                acc[v]  <= '0;
            end
            mix        <= '0;
            rom_addr_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (bus.wr_en && in_window) begin
                case (off)
                    5'h05: wave[0] <= nib[2:0];
                    5'h0A: wave[1] <= nib[2:0];
                    5'h0F: wave[2] <= nib[2:0];
                    5'h10, 5'h11, 5'h12, 5'h13, 5'h14:
                        freq[0][{off[2:0], 2'b00} +: 4] <= nib;
                    5'h15: vol[0] <= nib;
                    5'h16, 5'h17, 5'h18, 5'h19:
                        freq[1][{v1_idx, 2'b00} +: 4] <= nib;
                    5'h1A: vol[1] <= nib;
                    5'h1B, 5'h1C, 5'h1D, 5'h1E:
                        freq[2][{v2_idx, 2'b00} +: 4] <= nib;
                    5'h1F: vol[2] <= nib;
                    default: ;
                endcase
            end

            if (start) mix <= '0;
            if (acc_step) begin
                acc[voice] <= acc_sum;
                rom_addr_q <= {wave[voice], acc_sum[19:15]};
            end
            if (mac_step) mix <= mix + 10'(product);

            valid_q <= out_step;
            if (out_step) sample_q <= bus.snd_enable ? mix : 10'd0;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
endmodule
